// File: rtl/neural_soc_pio_pkg.sv
// neural_soc_pio_pkg
//   Shared definitions for the neural_soc input PIO: Avalon register
//   offsets, edge-type selector values and a helper that sizes the
//   debounce counter.
package neural_soc_pio_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'd0,
    REG_RSVD = 2'd1,
    REG_MASK = 2'd2,
    REG_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter width for a debounce length of n cycles. Never returns less
  // than 1 so a counter vector can always be declared.
  function automatic int cnt_width(input int n);
    int w;
    w = (n < 1) ? 1 : $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/neural_soc_pio_in_filter.sv
// neural_soc_pio_in_filter
//   One input bit: 2-FF synchroniser followed by an optional debounce
//   filter. With DEBOUNCE_CYCLES = 0 the synchronised value is passed
//   straight through; otherwise filt only follows the synchronised input
//   after it has differed for DEBOUNCE_CYCLES consecutive cycles.
// Ports
//   clk     in  1  system clock
//   reset   in  1  synchronous, active-high reset
//   in_bit  in  1  asynchronous external input
//   filt    out 1  synchronised (and optionally debounced) value
module neural_soc_pio_in_filter
  import neural_soc_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic filt
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = sync2;
    end else begin : g_debounce
      localparam int CW = cnt_width(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt_q;

      // The counter only runs while the input disagrees with filt; any
      // agreeing cycle restarts it, so short glitches never get through.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt    <= '0;
          filt_q <= 1'b0;
        end else if (sync2 == filt_q) begin
          cnt <= '0;
        end else if (cnt == TERM) begin
          filt_q <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end

      assign filt = filt_q;
    end
  endgenerate

endmodule

// File: rtl/neural_soc_pio_in_edge.sv
// neural_soc_pio_in_edge
//   Avalon-MM input PIO slave with per-bit synchroniser/debounce, edge
//   capture, interrupt mask and a level interrupt.
//   Register map: 0 data (RO), 1 reserved (0), 2 irq_mask (RW),
//   3 edge_capture (RO, write clears).
// Ports
//   clk         in  1      system clock
//   reset       in  1      synchronous, active-high reset
//   address     in  2      Avalon word offset
//   chipselect  in  1      Avalon select
//   write       in  1      write strobe, qualified by chipselect
//   writedata   in  32     write data, bits above WIDTH ignored
//   in_port     in  WIDTH  asynchronous external inputs
//   readdata    out 32     registered read data, zero-extended
//   irq         out 1      |(edge_capture & irq_mask)
module neural_soc_pio_in_edge
  import neural_soc_pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int CLEAR_ANY_WRITE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_d;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_cap;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_next;
  logic             wr_en;
  logic             unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      neural_soc_pio_in_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_filter (
        .clk   (clk),
        .reset (reset),
        .in_bit(in_port[i]),
        .filt  (filt[i])
      );
    end
  endgenerate

  assign wd           = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & write;

  always_comb begin
    edge_set = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_set = filt & ~filt_d;
      EDGE_FALL: edge_set = ~filt & filt_d;
      default:   edge_set = filt ^ filt_d;
    endcase
  end

  always_comb begin
    edge_clr = '0;
    if (wr_en && (reg_addr_e'(address) == REG_EDGE)) begin
      edge_clr = (CLEAR_ANY_WRITE != 0) ? '1 : wd;
    end
  end

  always_comb begin
    rd_next = '0;
    case (reg_addr_e'(address))
      REG_DATA: rd_next = 32'(filt);
      REG_RSVD: rd_next = '0;
      REG_MASK: rd_next = 32'(irq_mask);
      REG_EDGE: rd_next = 32'(edge_cap);
      default:  rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_d   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      readdata <= '0;
    end else begin
      filt_d   <= filt;
      // Applying the set after the clear makes a coincident edge win.
      edge_cap <= (edge_cap & ~edge_clr) | edge_set;
      readdata <= rd_next;
      if (wr_en && (reg_addr_e'(address) == REG_MASK)) begin
        irq_mask <= wd;
      end
    end
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_neural_soc_pio_in_edge.sv
// Bench for neural_soc_pio_in_edge: four differently parameterised
// instances share one Avalon bus, each with its own inputs, and are
// compared every cycle against a behavioural model.
module tb_neural_soc_pio_in_edge;

  localparam int P_W[4] = '{2, 2, 32, 8};
  localparam int P_E[4] = '{0, 0, 2, 1};
  localparam int P_D[4] = '{0, 4, 0, 2};
  localparam int P_C[4] = '{0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        bus_rst = 1'b1;
  logic        bus_cs = 1'b0;
  logic        bus_wr = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wd = '0;
  logic [31:0] in_v [4];
  logic [31:0] rd_v [4];
  logic        irq_v[4];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic [31:0] m_s1[4], m_s2[4], m_filt[4], m_fd[4];
  logic [31:0] m_mask[4], m_edge[4], m_rd[4];
  logic [31:0] m_hist[4][4];

  always #5 clk = ~clk;

  neural_soc_pio_in_edge #(.WIDTH(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0), .CLEAR_ANY_WRITE(0)) u_a (
    .clk(clk), .reset(bus_rst), .address(bus_addr), .chipselect(bus_cs), .write(bus_wr),
    .writedata(bus_wd), .in_port(in_v[0][1:0]), .readdata(rd_v[0]), .irq(irq_v[0]));
  neural_soc_pio_in_edge #(.WIDTH(2), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4), .CLEAR_ANY_WRITE(1)) u_b (
    .clk(clk), .reset(bus_rst), .address(bus_addr), .chipselect(bus_cs), .write(bus_wr),
    .writedata(bus_wd), .in_port(in_v[1][1:0]), .readdata(rd_v[1]), .irq(irq_v[1]));
  neural_soc_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(0), .CLEAR_ANY_WRITE(0)) u_c (
    .clk(clk), .reset(bus_rst), .address(bus_addr), .chipselect(bus_cs), .write(bus_wr),
    .writedata(bus_wd), .in_port(in_v[2]), .readdata(rd_v[2]), .irq(irq_v[2]));
  neural_soc_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(2), .CLEAR_ANY_WRITE(0)) u_d (
    .clk(clk), .reset(bus_rst), .address(bus_addr), .chipselect(bus_cs), .write(bus_wr),
    .writedata(bus_wd), .in_port(in_v[3][7:0]), .readdata(rd_v[3]), .irq(irq_v[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_irq(input int k);
    return |(m_edge[k] & m_mask[k]);
  endfunction

  // One clock edge of instance k, from the bus/input values present now.
  task automatic model_step(input int k);
    logic [31:0] wm, f, sel, clr, ne, nm, nr, nf, diff;
    wm  = (P_W[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << P_W[k]) - 32'd1);
    f   = (P_D[k] == 0) ? m_s2[k] : m_filt[k];
    case (P_E[k])
      0:       sel = f & ~m_fd[k];
      1:       sel = ~f & m_fd[k];
      default: sel = f ^ m_fd[k];
    endcase
    clr = '0;
    if (bus_cs && bus_wr && bus_addr == 2'd3) clr = (P_C[k] != 0) ? 32'hFFFF_FFFF : bus_wd;
    ne = ((m_edge[k] & ~clr) | sel) & wm;
    nm = (bus_cs && bus_wr && bus_addr == 2'd2) ? (bus_wd & wm) : m_mask[k];
    case (bus_addr)
      2'd0:    nr = f;
      2'd1:    nr = '0;
      2'd2:    nr = m_mask[k];
      default: nr = m_edge[k];
    endcase
    // the filtered value flips once the last D synchronised samples all disagree with it
    for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
    m_hist[k][0] = m_s2[k];
    nf = m_filt[k];
    if (P_D[k] > 0) begin
      diff = wm;
      for (int j = 0; j < P_D[k]; j++) diff = diff & (m_hist[k][j] ^ m_filt[k]);
      nf = m_filt[k] ^ diff;
    end
    if (bus_rst) begin
      m_s1[k] = '0; m_s2[k] = '0; m_filt[k] = '0; m_fd[k] = '0;
      m_mask[k] = '0; m_edge[k] = '0; m_rd[k] = '0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    end else begin
      m_edge[k] = ne; m_mask[k] = nm; m_rd[k] = nr; m_filt[k] = nf;
      m_fd[k] = f;
      m_s2[k] = m_s1[k];
      m_s1[k] = in_v[k] & wm;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 4; k++) model_step(k);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rd%0d", k), rd_v[k], m_rd[k]);
      chk($sformatf("irq%0d", k), {31'b0, irq_v[k]}, {31'b0, m_irq(k)});
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus_cs = 1'b1; bus_wr = 1'b1; bus_addr = a; bus_wd = d;
    tick();
    bus_cs = 1'b0; bus_wr = 1'b0;
  endtask

  initial begin
    int lat;
    for (int k = 0; k < 4; k++) begin
      in_v[k] = '0;
      m_s1[k] = '0; m_s2[k] = '0; m_filt[k] = '0; m_fd[k] = '0;
      m_mask[k] = '0; m_edge[k] = '0; m_rd[k] = '0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = '0;
    end

    // reset with inputs high, then propagation and capture after release
    in_v[0] = 32'h3;
    bus_rst = 1'b1;
    ticks(2);
    chk("reset_rd", rd_v[0], 32'h0);
    chk("reset_irq", {31'b0, irq_v[0]}, 32'h0);
    bus_rst = 1'b0;
    ticks(3);
    chk("post_reset_data", rd_v[0], 32'h3);
    bus_addr = 2'd3;
    ticks(2);
    chk("post_reset_edge", rd_v[0], 32'h3);

    // rising capture with mask, then clear
    bus_write(2'd3, 32'h3);
    in_v[0] = 32'h0;
    ticks(4);
    bus_write(2'd2, 32'h1);
    chk("mask_idle_irq", {31'b0, irq_v[0]}, 32'h0);
    in_v[0] = 32'h1;
    ticks(3);
    chk("rise_irq", {31'b0, irq_v[0]}, 32'h1);
    bus_write(2'd3, 32'h1);
    chk("clear_irq", {31'b0, irq_v[0]}, 32'h0);

    // clear write on the same edge a new rising edge is captured
    in_v[0] = 32'h0;
    ticks(4);
    in_v[0] = 32'h1;
    ticks(2);
    bus_write(2'd3, 32'h1);
    chk("collide_irq", {31'b0, irq_v[0]}, 32'h1);
    bus_addr = 2'd3;
    ticks(2);
    chk("collide_edge", rd_v[0], 32'h1);
    bus_write(2'd3, 32'h1);

    // debounce N=4 on instance 1: short pulse rejected, long pulse passes
    in_v[1] = 32'h2;
    ticks(3);
    in_v[1] = 32'h0;
    ticks(8);
    bus_addr = 2'd3;
    tick();
    chk("db_short_edge", rd_v[1], 32'h0);
    bus_addr = 2'd0;
    in_v[1] = 32'h2;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 6) in_v[1] = 32'h0;
      if (lat == 0 && rd_v[1] == 32'h2) lat = i;
    end
    chk("db_latency", 32'(lat), 32'd7);
    bus_addr = 2'd3;
    tick();
    chk("db_long_edge", rd_v[1], 32'h2);

    // any-edge on bit 31 of the 32-bit instance
    bus_write(2'd3, 32'hFFFF_FFFF);
    in_v[2] = 32'h8000_0000;
    ticks(5);
    bus_addr = 2'd3;
    tick();
    chk("any_rise", rd_v[2], 32'h8000_0000);
    bus_addr = 2'd0;
    tick();
    chk("any_data", rd_v[2], 32'h8000_0000);
    bus_write(2'd3, 32'h8000_0000);
    in_v[2] = 32'h0;
    ticks(5);
    bus_addr = 2'd3;
    tick();
    chk("any_fall", rd_v[2], 32'h8000_0000);
    bus_write(2'd3, 32'hFFFF_FFFF);

    // ignored writes, mask truncation, clear-on-any-write
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_addr = 2'd2;
    ticks(2);
    chk("mask_trunc_w2", rd_v[0], 32'h3);
    chk("mask_full_w32", rd_v[2], 32'hFFFF_FFFF);
    in_v[1] = 32'h1;
    ticks(10);
    bus_addr = 2'd3;
    tick();
    chk("clr_any_pre", rd_v[1], 32'h1);
    bus_write(2'd3, 32'h0);
    chk("clr_any_irq", {31'b0, irq_v[1]}, 32'h0);
    bus_addr = 2'd3;
    tick();
    chk("clr_any_edge", rd_v[1], 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus_rst  = ($urandom_range(0, 399) == 0);
      bus_addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 3) begin
        bus_cs = 1'b1; bus_wr = 1'b1;
      end else begin
        bus_cs = 1'($urandom_range(0, 1));
        bus_wr = ~bus_cs & 1'($urandom_range(0, 1));
      end
      bus_wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      for (int k = 0; k < 4; k++) in_v[k] = in_v[k] ^ ($urandom & $urandom & $urandom);
      tick();
    end
    bus_rst = 1'b0; bus_cs = 1'b0; bus_wr = 1'b0;
    ticks(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
